// File: rtl/bn_relu_serializer_pkg.sv
// Shared FP16 constants and types for the batch-norm ReLU serializer.
//   FP16_W / FP16_SIGN : half-precision word width and sign bit position
//   FP16_ZERO          : +0.0, the value negative lanes collapse to
//   FP16_ONE           : +1.0, handy reference value for stimulus
//   state_t            : serializer FSM states
package bn_relu_serializer_pkg;

    localparam int FP16_W    = 16;
    localparam int FP16_SIGN = 15;

    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

    typedef logic [FP16_W-1:0] fp16_t;

    // IDLE: nothing held. SEND: holding register valid, lane counter
    // points at the next lane to emit.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/bn_relu_serializer_fp16_relu.sv
// Combinational FP16 ReLU for one lane.
//   RELU_EN : 1 clamps any value with the sign bit set to +0.0,
//             0 passes the value through untouched.
//   in_val  : FP16 input lane
//   out_val : FP16 output lane
// Only the sign bit is inspected, so -0, negative subnormals, -inf and
// negative NaNs all become +0, while +inf and +NaN pass unchanged.
module fp16_relu
    import bn_relu_serializer_pkg::*;
#(
    parameter bit RELU_EN = 1'b1
) (
    input  logic [FP16_W-1:0] in_val,
    output logic [FP16_W-1:0] out_val
);

    assign out_val = (RELU_EN && in_val[FP16_SIGN]) ? FP16_ZERO : in_val;

endmodule

// File: rtl/bn_relu_serializer.sv
// Batch-norm output serializer: accepts one SIZE-lane FP16 vector per
// handshake, applies an optional per-lane ReLU and emits the lanes one per
// cycle on a 16-bit valid/ready stream, flagging the last lane.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : input vector handshake
//   in_data             : packed vector, lane 0 in the leftmost 16 bits
//   out_valid/out_ready : output lane handshake
//   out_data            : post-ReLU FP16 lane
//   out_lane / out_last : lane index, high on lane SIZE-1
//   vec_cnt             : count of fully emitted vectors (wraps)
module bn_relu_serializer
    import bn_relu_serializer_pkg::*;
#(
    parameter int  SIZE    = 4,
    parameter bit  RELU_EN = 1'b1,
    localparam int LW      = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FP16_W*SIZE-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FP16_W-1:0]      out_data,
    output logic [LW-1:0]          out_lane,
    output logic                   out_last,
    output logic [15:0]            vec_cnt
);

    localparam logic [LW-1:0] LAST_LANE = LW'(SIZE - 1);

    state_t        state_q;
    logic [LW-1:0] lane_q;
    fp16_t         hold_q [SIZE];
    logic [15:0]   vec_cnt_q;

    fp16_t         relu_lane [SIZE];

    logic          sending;
    logic          at_last;
    logic          out_fire;
    logic          accept;

    // ReLU sits on the input side so the holding register already contains
    // final values and the output path is a plain mux of registered state.
    for (genvar g = 0; g < SIZE; g++) begin : g_relu
        fp16_relu #(
            .RELU_EN (RELU_EN)
        ) u_relu (
            .in_val  (in_data[(SIZE-1-g)*FP16_W +: FP16_W]),
            .out_val (relu_lane[g])
        );
    end

    assign sending  = (state_q == SEND);
    assign at_last  = (lane_q == LAST_LANE);
    assign out_fire = sending & out_ready;

    // Combinational from out_ready on purpose: a new vector may load in the
    // same cycle the last lane leaves, which keeps back-to-back vectors
    // free of bubbles.
    assign in_ready = ~sending | (at_last & out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            vec_cnt_q <= '0;
            // NOTE: the holding register is cleared too, so a vector that was
            // discarded by reset leaves no trace in the datapath.
            for (int i = 0; i < SIZE; i++) begin
                hold_q[i] <= FP16_ZERO;
            end
        end else begin
            // NOTE: all state updates use non-blocking assignments so every
            // register sees pre-edge values regardless of statement order.
            if (out_fire && at_last) begin
                vec_cnt_q <= vec_cnt_q + 1'b1;
            end

            if (accept) begin
                for (int i = 0; i < SIZE; i++) begin
                    hold_q[i] <= relu_lane[i];
                end
                lane_q  <= '0;
                state_q <= SEND;
            end else if (out_fire) begin
                if (at_last) begin
                    state_q <= IDLE;
                end else begin
                    lane_q <= lane_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through this
        // block can infer a latch.
        out_valid = sending;
        out_data  = FP16_ZERO;
        out_lane  = '0;
        out_last  = 1'b0;
        if (sending) begin
            out_data = hold_q[lane_q];
            out_lane = lane_q;
            out_last = at_last;
        end
    end

    assign vec_cnt = vec_cnt_q;

endmodule

// File: tb/tb_bn_relu_serializer.sv
// Self-checking bench for bn_relu_serializer. Two SIZE=4 instances (ReLU on
// and off) share stimulus and are checked against a lane-queue model; a
// SIZE=1 instance covers the single-lane case and the vec_cnt wrap.
module tb_bn_relu_serializer;
    import bn_relu_serializer_pkg::*;

    localparam int SIZE = 4;
    localparam int LW   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // shared stimulus for the two SIZE=4 instances
    logic                   in_valid;
    logic                   out_ready;
    logic [FP16_W*SIZE-1:0] in_data;

    logic          a_in_ready, a_out_valid, a_out_last;
    logic [15:0]   a_out_data, a_vec_cnt;
    logic [LW-1:0] a_out_lane;
    logic          b_in_ready, b_out_valid, b_out_last;
    logic [15:0]   b_out_data, b_vec_cnt;
    logic [LW-1:0] b_out_lane;

    // SIZE=1 instance
    logic        s_in_valid, s_out_ready, s_in_ready, s_out_valid, s_out_last;
    logic [15:0] s_in_data, s_out_data, s_vec_cnt;
    logic [0:0]  s_out_lane;

    bn_relu_serializer #(.SIZE(SIZE), .RELU_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_lane(a_out_lane), .out_last(a_out_last),
        .vec_cnt(a_vec_cnt)
    );

    bn_relu_serializer #(.SIZE(SIZE), .RELU_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_lane(b_out_lane), .out_last(b_out_last),
        .vec_cnt(b_vec_cnt)
    );

    bn_relu_serializer #(.SIZE(1), .RELU_EN(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_lane(s_out_lane), .out_last(s_out_last),
        .vec_cnt(s_vec_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of raw lanes still to be emitted, in order.
    logic [15:0] q_data [$];
    int          q_lane [$];
    int          exp_vec  = 0;
    bit          last_acc = 1'b0;

    function automatic logic [15:0] relu(input logic [15:0] v, input bit en);
        return (en && v[15]) ? 16'h0000 : v;
    endfunction

    function automatic logic [15:0] lane_of(input logic [FP16_W*SIZE-1:0] vec, input int i);
        return vec[(SIZE-1-i)*16 +: 16];
    endfunction

    function automatic logic [15:0] rand_lane();
        logic [15:0] specials [6];
        specials = '{16'hFC00, 16'h7C00, 16'hFE00, 16'h7E00, 16'h8000, 16'h8001};
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    function automatic logic [FP16_W*SIZE-1:0] rand_vec();
        logic [FP16_W*SIZE-1:0] v;
        for (int i = 0; i < SIZE; i++) v[(SIZE-1-i)*16 +: 16] = rand_lane();
        return v;
    endfunction

    // One clock cycle: inputs are already driven; check outputs against the
    // model, advance the model by the handshakes that occur, then step.
    task automatic cycle();
        bit exp_rdy;
        bit have;
        #2;
        have    = (q_data.size() != 0);
        exp_rdy = !have || (q_data.size() == 1 && out_ready);
        check("a_in_ready", a_in_ready, exp_rdy);
        check("b_in_ready", b_in_ready, exp_rdy);
        check("a_out_valid", a_out_valid, have);
        check("b_out_valid", b_out_valid, have);
        if (have) begin
            check("a_out_data", a_out_data, relu(q_data[0], 1'b1));
            check("b_out_data", b_out_data, relu(q_data[0], 1'b0));
            check("a_out_lane", a_out_lane, q_lane[0]);
            check("b_out_lane", b_out_lane, q_lane[0]);
            check("a_out_last", a_out_last, q_lane[0] == SIZE - 1);
            check("b_out_last", b_out_last, q_lane[0] == SIZE - 1);
        end else begin
            check("a_idle_data", a_out_data, 16'h0000);
            check("b_idle_data", b_out_data, 16'h0000);
            check("a_idle_lane", a_out_lane, 0);
            check("a_idle_last", a_out_last, 1'b0);
        end
        check("a_vec_cnt", a_vec_cnt, exp_vec[15:0]);
        check("b_vec_cnt", b_vec_cnt, exp_vec[15:0]);
        if (have && out_ready) begin
            if (q_lane[0] == SIZE - 1) exp_vec++;
            void'(q_data.pop_front());
            void'(q_lane.pop_front());
        end
        last_acc = in_valid && exp_rdy;
        if (last_acc) begin
            for (int i = 0; i < SIZE; i++) begin
                q_data.push_back(lane_of(in_data, i));
                q_lane.push_back(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_acc;
        int guard;
        int n;

        reset       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data     = '0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        s_in_data   = '0;

        // reset state
        @(posedge clk); #1;
        check("rst_a_out_valid", a_out_valid, 1'b0);
        check("rst_a_out_data", a_out_data, 16'h0000);
        check("rst_a_out_lane", a_out_lane, 0);
        check("rst_a_out_last", a_out_last, 1'b0);
        check("rst_a_vec_cnt", a_vec_cnt, 16'h0000);
        check("rst_s_out_valid", s_out_valid, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        cycle();

        // basic vector: expect 3C00, 0000, 0000, 4500 in cycles t+1..t+4
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {FP16_ONE, 16'hBC00, 16'h8000, 16'h4500};
        cycle();
        in_valid = 1'b0;
        repeat (5) cycle();
        check("basic_vec_cnt", a_vec_cnt, 16'd1);

        // back-to-back: two vectors with in_valid held
        n_acc    = 0;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = rand_vec();
        while (n_acc < 2 && guard < 20) begin
            cycle();
            guard++;
            if (last_acc) begin
                n_acc++;
                in_data = rand_vec();
            end
        end
        check("b2b_accepts", n_acc, 2);
        in_valid = 1'b0;
        repeat (8) cycle();
        check("b2b_vec_cnt", a_vec_cnt, 16'd3);

        // backpressure at lane 2 for 3 cycles
        in_valid = 1'b1;
        in_data  = rand_vec();
        cycle();
        in_valid = 1'b0;
        in_data  = rand_vec();   // later in_data changes must not matter
        repeat (2) cycle();
        out_ready = 1'b0;
        repeat (3) cycle();
        out_ready = 1'b1;
        repeat (3) cycle();

        // special values
        in_valid = 1'b1;
        in_data  = {16'hFC00, 16'h7C00, 16'hFE00, 16'h7E00};
        cycle();
        in_valid = 1'b0;
        repeat (5) cycle();

        // reset while lane 1 is on the outputs
        in_valid = 1'b1;
        in_data  = rand_vec();
        cycle();
        in_valid = 1'b0;
        cycle();
        check("pre_rst_lane", a_out_lane, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_a_valid", a_out_valid, 1'b0);
        check("mid_rst_b_valid", b_out_valid, 1'b0);
        check("mid_rst_a_vec", a_vec_cnt, 16'h0000);
        q_data.delete();
        q_lane.delete();
        exp_vec = 0;
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_vec();
        cycle();
        in_valid = 1'b0;
        repeat (5) cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = rand_vec();
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2 * SIZE + 2) cycle();

        // SIZE=1 instance: out_last tracks out_valid, then vec_cnt wrap
        s_in_valid  = 1'b1;
        s_out_ready = 1'b1;
        s_in_data   = 16'hBC00;
        #2;
        check("s_in_ready", s_in_ready, 1'b1);
        check("s_idle_valid", s_out_valid, 1'b0);
        check("s_idle_last", s_out_last, 1'b0);
        @(posedge clk); #1;
        #2;
        check("s_valid", s_out_valid, 1'b1);
        check("s_data_neg", s_out_data, 16'h0000);
        check("s_last", s_out_last, 1'b1);
        check("s_lane", s_out_lane, 1'b0);
        check("s_in_ready_send", s_in_ready, 1'b1);
        n = 1;
        s_in_data = FP16_ONE;
        @(posedge clk); #1;
        #2;
        check("s_data_one", s_out_data, FP16_ONE);
        check("s_last2", s_out_last, 1'b1);
        n = 2;
        @(posedge clk); #1;
        guard = 0;
        while (n < 65535 && guard < 70000) begin
            #2;
            if (s_out_valid) n++;
            @(posedge clk); #1;
            guard++;
        end
        check("s_wrap_progress", n, 65535);
        check("s_vec_ffff", s_vec_cnt, 16'hFFFF);
        s_in_valid = 1'b0;
        #2;
        check("s_final_valid", s_out_valid, 1'b1);
        @(posedge clk); #1;
        check("s_vec_wrap", s_vec_cnt, 16'h0000);
        check("s_drained", s_out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
